// File: rtl/sborshchik_otvetov_banok.sv
// Return-path collector: puts per-bank read data back into CPU issue order.
// Optional same-cycle head bypass enabled by macro SBORSHCHIK_BYPASS_EN.
module sborshchik_otvetov_banok #(
    parameter int NUM_BANKS      = 3,
    parameter int SHIRINA_DANNYH = 32,
    parameter int GLUBINA        = 4,
    parameter int SHIRINA_NOMERA = $clog2(NUM_BANKS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_BANKS-1:0]                gnt_robin,
    input  logic [NUM_BANKS-1:0]                rvalid_banki,
    input  logic [NUM_BANKS*SHIRINA_DANNYH-1:0] rdata_banki,
    output logic                                rvalid_cpu,
    output logic [SHIRINA_DANNYH-1:0]           rdata_cpu,
    output logic                                stall_cpu,
    output logic                                pusto,
    output logic                                oshibka
);
    localparam int NW = (SHIRINA_NOMERA > 0) ? SHIRINA_NOMERA : 1;
    localparam int PW = $clog2(GLUBINA);
    localparam int CW = $clog2(GLUBINA + 1);
    localparam int W  = SHIRINA_DANNYH;

    logic [NW-1:0] r_tag_mem [GLUBINA];
    logic [PW-1:0] r_tag_wp, r_tag_rp;
    logic [CW-1:0] r_tag_cnt;
    logic [W-1:0]  r_dat_mem [NUM_BANKS][GLUBINA];
    logic [PW-1:0] r_dat_wp  [NUM_BANKS];
    logic [PW-1:0] r_dat_rp  [NUM_BANKS];
    logic [CW-1:0] r_dat_cnt [NUM_BANKS];
    logic [CW-1:0] r_out_cnt [NUM_BANKS];
    logic          r_rvalid_cpu, r_pusto, r_oshibka;
    logic [W-1:0]  r_rdata_cpu;

    logic [NW-1:0]        w_gnt_idx, w_head;
    logic                 w_gnt_any, w_gnt_onehot;
    logic                 w_head_ne, w_head_rv, w_tag_ne, w_full;
    logic [W-1:0]         w_head_dat, w_head_byp_dat;
    logic                 w_pop_fifo, w_pop_byp, w_pop, w_push, w_err, w_all_empty;
    logic [NUM_BANKS-1:0] w_gnt_ok, w_rv_ok, w_wr, w_rd;

    assign w_gnt_any    = |gnt_robin;
    assign w_gnt_onehot = $onehot(gnt_robin);
    assign w_head       = r_tag_mem[r_tag_rp];
    assign w_tag_ne     = (r_tag_cnt != '0);
    assign w_full       = (r_tag_cnt == CW'(GLUBINA));

    always_comb begin
        w_gnt_idx      = '0;
        w_head_ne      = 1'b0;
        w_head_rv      = 1'b0;
        w_head_dat     = '0;
        w_head_byp_dat = '0;
        w_all_empty    = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_robin[b]) w_gnt_idx = NW'(b);
            if (r_dat_cnt[b] != '0) w_all_empty = 1'b0;
            if (w_head == NW'(b)) begin
                w_head_ne      = (r_dat_cnt[b] != '0);
                w_head_dat     = r_dat_mem[b][r_dat_rp[b]];
                w_head_byp_dat = rdata_banki[b*W +: W];
                // The head bank always has an outstanding request, so no grant term is needed here.
                w_head_rv      = rvalid_banki[b] && (r_out_cnt[b] != '0);
            end
        end
    end

    assign w_pop_fifo = w_tag_ne && w_head_ne;
`ifdef SBORSHCHIK_BYPASS_EN
    assign w_pop_byp  = w_tag_ne && !w_head_ne && w_head_rv;
`else
    assign w_pop_byp  = 1'b0;
`endif
    assign w_pop      = w_pop_fifo || w_pop_byp;
    assign w_push     = w_gnt_onehot && (!w_full || w_pop);
    assign w_gnt_ok   = gnt_robin & {NUM_BANKS{w_push}};

    always_comb begin
        w_rv_ok = '0;
        w_wr    = '0;
        w_rd    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rv_ok[b] = rvalid_banki[b] && ((r_out_cnt[b] != '0) || w_gnt_ok[b]);
            w_wr[b]    = w_rv_ok[b] && !(w_pop_byp && (w_head == NW'(b)));
            w_rd[b]    = w_pop_fifo && (w_head == NW'(b));
        end
    end

    assign w_err = (w_gnt_any && !w_gnt_onehot) || (w_gnt_onehot && !w_push)
                 || (|(rvalid_banki & ~w_rv_ok));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wp     <= '0;
            r_tag_rp     <= '0;
            r_tag_cnt    <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_dat_wp[b]  <= '0;
                r_dat_rp[b]  <= '0;
                r_dat_cnt[b] <= '0;
                r_out_cnt[b] <= '0;
            end
            r_rvalid_cpu <= 1'b0;
            r_rdata_cpu  <= '0;
            r_pusto      <= 1'b1;
            r_oshibka    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_tag_wp] <= w_gnt_idx;
                r_tag_wp            <= r_tag_wp + PW'(1);
            end
            if (w_pop) r_tag_rp <= r_tag_rp + PW'(1);
            r_tag_cnt <= r_tag_cnt + CW'(w_push) - CW'(w_pop);
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_wr[b]) begin
                    r_dat_mem[b][r_dat_wp[b]] <= rdata_banki[b*W +: W];
                    r_dat_wp[b]               <= r_dat_wp[b] + PW'(1);
                end
                if (w_rd[b]) r_dat_rp[b] <= r_dat_rp[b] + PW'(1);
                r_dat_cnt[b] <= r_dat_cnt[b] + CW'(w_wr[b]) - CW'(w_rd[b]);
                r_out_cnt[b] <= r_out_cnt[b] + CW'(w_gnt_ok[b]) - CW'(w_rv_ok[b]);
            end
            r_rvalid_cpu <= w_pop;
            if (w_pop) r_rdata_cpu <= w_pop_byp ? w_head_byp_dat : w_head_dat;
            // Reflects the state at the previous edge, so it lags the FIFOs by one cycle.
            r_pusto <= !w_tag_ne && w_all_empty;
            if (w_err) r_oshibka <= 1'b1;
        end
    end

    assign rvalid_cpu = r_rvalid_cpu;
    assign rdata_cpu  = r_rdata_cpu;
    assign stall_cpu  = w_full;
    assign pusto      = r_pusto;
    assign oshibka    = r_oshibka;
endmodule

// File: tb/tb_sborshchik_otvetov_banok.sv
// Bench for sborshchik_otvetov_banok: directed plan scenarios plus random legal traffic vs a queue model.
module tb_sborshchik_otvetov_banok;
    localparam int G = 4;
`ifdef SBORSHCHIK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  gnt_robin, rvalid_banki;
    logic [95:0] rdata_banki;
    logic        rvalid_cpu, stall_cpu, pusto, oshibka;
    logic [31:0] rdata_cpu;

    sborshchik_otvetov_banok dut (
        .clk(clk), .rst(rst), .gnt_robin(gnt_robin), .rvalid_banki(rvalid_banki),
        .rdata_banki(rdata_banki), .rvalid_cpu(rvalid_cpu), .rdata_cpu(rdata_cpu),
        .stall_cpu(stall_cpu), .pusto(pusto), .oshibka(oshibka)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tag order queue, per-bank data queues, outstanding counts.
    int          tagq[$];
    logic [31:0] dq[3][$];
    int          outst[3];
    logic        e_rv, e_stall, e_pu, e_err;
    logic [31:0] e_rd;
    logic [31:0] got[$];
    logic [2:0]  rg, rvv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [2:0] g, input logic [2:0] v,
                              input logic [95:0] d);
        int  nones, gb, h;
        bit  full, pop_f, byp, pop, push, prev_empty;
        bit  ok[3];
        if (r) begin
            tagq.delete();
            for (int b = 0; b < 3; b++) begin dq[b].delete(); outst[b] = 0; end
            e_rv = 0; e_rd = '0; e_pu = 1; e_err = 0; e_stall = 0;
            return;
        end
        prev_empty = (tagq.size() == 0);
        for (int b = 0; b < 3; b++) if (dq[b].size() != 0) prev_empty = 0;
        nones = $countones(g);
        gb = -1;
        for (int b = 0; b < 3; b++) if (g[b]) gb = b;
        full  = (tagq.size() == G);
        pop_f = (tagq.size() > 0) && (dq[tagq[0]].size() > 0);
        byp   = BYP && (tagq.size() > 0) && !pop_f && v[tagq[0]] && (outst[tagq[0]] > 0);
        pop   = pop_f || byp;
        push  = (nones == 1) && (!full || pop);
        if (nones > 1 || (nones == 1 && !push)) e_err = 1;
        for (int b = 0; b < 3; b++) begin
            ok[b] = v[b] && (outst[b] > 0 || (push && gb == b));
            if (v[b] && !ok[b]) e_err = 1;
        end
        h = -1;
        e_rv = pop;
        if (pop) begin
            h = tagq.pop_front();
            if (byp) e_rd = d[h*32 +: 32];
            else     e_rd = dq[h].pop_front();
        end
        if (push) begin tagq.push_back(gb); outst[gb]++; end
        for (int b = 0; b < 3; b++) begin
            if (ok[b]) begin
                outst[b]--;
                if (!(byp && b == h)) dq[b].push_back(d[b*32 +: 32]);
            end
        end
        e_stall = (tagq.size() == G);
        e_pu    = prev_empty;
    endtask

    task automatic cyc(input logic r, input logic [2:0] g, input logic [2:0] v,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        rst = r; gnt_robin = g; rvalid_banki = v; rdata_banki = {d2, d1, d0};
        model_step(r, g, v, {d2, d1, d0});
        @(posedge clk);
        #1;
        chk("rvalid_cpu", {31'd0, rvalid_cpu}, {31'd0, e_rv});
        chk("rdata_cpu",  rdata_cpu, e_rd);
        chk("stall_cpu",  {31'd0, stall_cpu}, {31'd0, e_stall});
        chk("pusto",      {31'd0, pusto}, {31'd0, e_pu});
        chk("oshibka",    {31'd0, oshibka}, {31'd0, e_err});
        if (rvalid_cpu === 1'b1) got.push_back(rdata_cpu);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 3'b000, 3'b000, 0, 0, 0);
    endtask

    initial begin
        rst = 1; gnt_robin = 0; rvalid_banki = 0; rdata_banki = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("reset_rdata", rdata_cpu, 32'h0);
        chk("reset_pusto", {31'd0, pusto}, 32'd1);

        // Single read
        cyc(0, 3'b010, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 3'b010, 0, 32'hA5A5_0001, 0);
`ifdef SBORSHCHIK_BYPASS_EN
        chk("single_vld", {31'd0, rvalid_cpu}, 32'd1);
        chk("single_dat", rdata_cpu, 32'hA5A5_0001);
        idle(1);
        chk("single_pusto", {31'd0, pusto}, 32'd1);
`else
        idle(1);
        chk("single_vld", {31'd0, rvalid_cpu}, 32'd1);
        chk("single_dat", rdata_cpu, 32'hA5A5_0001);
        idle(1);
        chk("single_pusto", {31'd0, pusto}, 32'd1);
`endif

        // Reordering across banks
        got.delete();
        cyc(0, 3'b001, 0, 0, 0, 0);
        cyc(0, 3'b100, 0, 0, 0, 0);
        cyc(0, 0, 3'b100, 0, 0, 32'h22);
        idle(2);
        cyc(0, 0, 3'b001, 32'h11, 0, 0);
        idle(4);
        chk("reorder_cnt", got.size(), 2);
        chk("reorder_1st", got[0], 32'h11);
        chk("reorder_2nd", got[1], 32'h22);

        // Full / stall
        for (int i = 0; i < 4; i++) cyc(0, 3'b010, 0, 0, 0, 0);
        chk("full_stall", {31'd0, stall_cpu}, 32'd1);
`ifdef SBORSHCHIK_BYPASS_EN
        cyc(0, 0, 3'b010, 0, 32'h100, 0);
        chk("stall_release", {31'd0, stall_cpu}, 32'd0);
        cyc(0, 3'b010, 0, 0, 0, 0);
        cyc(0, 3'b010, 3'b010, 0, 32'h101, 0);
`else
        cyc(0, 0, 3'b010, 0, 32'h100, 0);
        idle(1);
        chk("stall_release", {31'd0, stall_cpu}, 32'd0);
        cyc(0, 3'b010, 0, 0, 0, 0);
        cyc(0, 0, 3'b010, 0, 32'h101, 0);
        cyc(0, 3'b010, 0, 0, 0, 0);
`endif
        chk("push_pop_full", {31'd0, stall_cpu}, 32'd1);
        chk("push_pop_noerr", {31'd0, oshibka}, 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 3'b010, 0, 32'h200 + i, 0);
        idle(3);

        // Simultaneous returns
        got.delete();
        cyc(0, 3'b001, 0, 0, 0, 0);
        cyc(0, 3'b010, 0, 0, 0, 0);
        cyc(0, 3'b100, 0, 0, 0, 0);
        cyc(0, 0, 3'b111, 32'd1, 32'd2, 32'd3);
        idle(4);
        chk("simul_cnt", got.size(), 3);
        chk("simul_1", got[0], 32'd1);
        chk("simul_3", got[2], 32'd3);

        // Violations
        cyc(0, 3'b011, 0, 0, 0, 0);
        chk("viol_gnt", {31'd0, oshibka}, 32'd1);
        idle(2);
        chk("viol_no_tag", {31'd0, pusto}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("viol_rst", {31'd0, oshibka}, 32'd0);
        cyc(0, 0, 3'b001, 32'hDEAD, 0, 0);
        chk("viol_rv", {31'd0, oshibka}, 32'd1);
        idle(2);
        chk("viol_fifo_empty", {31'd0, pusto}, 32'd1);

        // Reset mid-flight
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 3'b001, 0, 0, 0, 0);
        cyc(0, 3'b010, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("mid_rst_pusto", {31'd0, pusto}, 32'd1);
        chk("mid_rst_stall", {31'd0, stall_cpu}, 32'd0);
        cyc(0, 0, 3'b001, 32'h77, 0, 0);
        chk("late_resp", {31'd0, oshibka}, 32'd1);

        // Random legal traffic
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            rg = 0;
            if (tagq.size() < G && $urandom_range(0, 1) == 1) rg = 3'(1 << $urandom_range(0, 2));
            rvv = 0;
            for (int b = 0; b < 3; b++) if (outst[b] > 0 && $urandom_range(0, 2) == 0) rvv[b] = 1;
            cyc(0, rg, rvv, $urandom, $urandom, $urandom);
        end
        for (int i = 0; i < 40; i++) begin
            rvv = 0;
            for (int b = 0; b < 3; b++) if (outst[b] > 0) rvv[b] = 1;
            cyc(0, 0, rvv, $urandom, $urandom, $urandom);
        end
        chk("rand_drain_pusto", {31'd0, pusto}, 32'd1);
        chk("rand_no_err", {31'd0, oshibka}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
